// File: rtl/hazard_pkg.sv
// Shared constants for the MIPS hazard unit: operand "not read" code,
// mult/div kinds, forwarding source encoding and default unit latencies.
package hazard_pkg;

  localparam int TW_DEFAULT = 2;
  localparam logic [TW_DEFAULT-1:0] TUSE_NONE = '1;

  typedef enum logic {
    MD_KIND_MULT = 1'b0,
    MD_KIND_DIV  = 1'b1
  } md_kind_e;

  localparam int FWD_RF = 0;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  localparam int GPR_AW = 5;

endpackage

// File: rtl/hazard_scoreboard_md.sv
// Mult/div occupancy counter: loads the unit latency on issue and counts
// down to zero; busy while non-zero.
module md_busy_counter
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic kind_i,
  output logic busy_o
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = (kind_i == MD_KIND_DIV) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end else if (count_q != '0) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign busy_o = (count_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: scoreboard of in-flight GPR writes driving the
// D stall and forwarding selects, plus the HI/LO busy interlock.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int STAGES      = 3,
  parameter int TW          = 2,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         d_valid,
  input  logic [GPR_AW-1:0]            d_rs,
  input  logic [GPR_AW-1:0]            d_rt,
  input  logic [TW-1:0]                d_tuse_rs,
  input  logic [TW-1:0]                d_tuse_rt,
  input  logic                         d_regwrite,
  input  logic [GPR_AW-1:0]            d_wreg,
  input  logic [TW-1:0]                d_tnew,
  input  logic                         d_md_start,
  input  logic                         d_md_kind,
  input  logic                         d_md_use,
  output logic                         stall,
  output logic [$clog2(STAGES+1)-1:0]  fwd_rs_sel,
  output logic [$clog2(STAGES+1)-1:0]  fwd_rt_sel,
  output logic                         md_busy
);

  localparam int SELW = $clog2(STAGES + 1);

  logic              sb_valid_q [STAGES];
  logic              sb_valid_d [STAGES];
  logic [GPR_AW-1:0] sb_wreg_q  [STAGES];
  logic [GPR_AW-1:0] sb_wreg_d  [STAGES];
  logic [TW-1:0]     sb_tnew_q  [STAGES];
  logic [TW-1:0]     sb_tnew_d  [STAGES];

  logic            rs_hit, rt_hit;
  logic [TW-1:0]   rs_tnew, rt_tnew;
  logic [SELW-1:0] rs_sel, rt_sel;
  logic            rs_data_stall, rt_data_stall, md_stall;
  logic            md_load;

  // Entry 0 is E; a stalled D instruction enters as a bubble.
  for (genvar k = 0; k < STAGES; k++) begin : g_entry
    if (k == 0) begin : g_head
      assign sb_valid_d[k] = d_valid & d_regwrite & (d_wreg != '0) & ~stall;
      assign sb_wreg_d[k]  = d_wreg;
      assign sb_tnew_d[k]  = d_tnew;
    end else begin : g_shift
      assign sb_valid_d[k] = sb_valid_q[k-1];
      assign sb_wreg_d[k]  = sb_wreg_q[k-1];
      assign sb_tnew_d[k]  = (sb_tnew_q[k-1] == '0) ? '0 : sb_tnew_q[k-1] - TW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sb_valid_q[k] <= 1'b0;
        sb_wreg_q[k]  <= '0;
        sb_tnew_q[k]  <= '0;
      end else begin
        sb_valid_q[k] <= sb_valid_d[k];
        sb_wreg_q[k]  <= sb_wreg_d[k];
        sb_tnew_q[k]  <= sb_tnew_d[k];
      end
    end
  end

  // Scan oldest to youngest so the youngest matching entry is the one kept.
  always_comb begin
    rs_hit  = 1'b0;
    rs_tnew = '0;
    rs_sel  = '0;
    rt_hit  = 1'b0;
    rt_tnew = '0;
    rt_sel  = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (sb_valid_q[k] && (sb_wreg_q[k] == d_rs)) begin
        rs_hit  = 1'b1;
        rs_tnew = sb_tnew_q[k];
        rs_sel  = SELW'(k + 1);
      end
      if (sb_valid_q[k] && (sb_wreg_q[k] == d_rt)) begin
        rt_hit  = 1'b1;
        rt_tnew = sb_tnew_q[k];
        rt_sel  = SELW'(k + 1);
      end
    end
    if ((d_rs == '0) || (&d_tuse_rs)) begin
      rs_hit = 1'b0;
    end
    if ((d_rt == '0) || (&d_tuse_rt)) begin
      rt_hit = 1'b0;
    end
  end

  always_comb begin
    rs_data_stall = rs_hit && (rs_tnew > d_tuse_rs);
    rt_data_stall = rt_hit && (rt_tnew > d_tuse_rt);
    md_stall      = d_valid && (d_md_use || d_md_start) && md_busy;
    stall         = rs_data_stall || rt_data_stall || md_stall;
    fwd_rs_sel    = (rs_hit && (rs_tnew == '0)) ? rs_sel : SELW'(FWD_RF);
    fwd_rt_sel    = (rt_hit && (rt_tnew == '0)) ? rt_sel : SELW'(FWD_RF);
  end

  assign md_load = d_valid & d_md_start & ~stall;

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_counter (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .load_i (md_load),
    .kind_i (d_md_kind),
    .busy_o (md_busy)
  );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, branch forwarding, $0,
// youngest-match, W forwarding, mult interlock and reset mid-divide.
module tb_hazard_scoreboard;

  logic       clk;
  logic       rst_n;
  logic       d_valid;
  logic [4:0] d_rs, d_rt;
  logic [1:0] d_tuse_rs, d_tuse_rt;
  logic       d_regwrite;
  logic [4:0] d_wreg;
  logic [1:0] d_tnew;
  logic       d_md_start, d_md_kind, d_md_use;
  logic       stall;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;
  logic       md_busy;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_scoreboard dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_valid    (d_valid),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_regwrite (d_regwrite),
    .d_wreg     (d_wreg),
    .d_tnew     (d_tnew),
    .d_md_start (d_md_start),
    .d_md_kind  (d_md_kind),
    .d_md_use   (d_md_use),
    .stall      (stall),
    .fwd_rs_sel (fwd_rs_sel),
    .fwd_rt_sel (fwd_rt_sel),
    .md_busy    (md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input int rs, input int tu_rs,
                       input int rt, input int tu_rt, input logic rw,
                       input int wreg, input int tnew, input logic mds,
                       input logic mdk, input logic mdu);
    d_valid    = v;
    d_rs       = 5'(rs);
    d_tuse_rs  = 2'(tu_rs);
    d_rt       = 5'(rt);
    d_tuse_rt  = 2'(tu_rt);
    d_regwrite = rw;
    d_wreg     = 5'(wreg);
    d_tnew     = 2'(tnew);
    d_md_start = mds;
    d_md_kind  = mdk;
    d_md_use   = mdu;
    #1;
  endtask

  task automatic nop();
    drive(1'b0, 0, 3, 0, 3, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow the settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (4) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    nop();
    #2;
    chk("reset_stall", int'(stall), 0);
    chk("reset_fwd_rs", int'(fwd_rs_sel), 0);
    chk("reset_fwd_rt", int'(fwd_rt_sel), 0);
    chk("reset_md_busy", int'(md_busy), 0);
    #10 rst_n = 1'b1;
    tick();

    // load-use: lw $8 (tnew 2), addu reads $8 with tuse 1
    drive(1'b1, 29, 1, 0, 3, 1'b1, 8, 2, 1'b0, 1'b0, 1'b0);
    chk("lw_no_stall", int'(stall), 0);
    tick();
    drive(1'b1, 8, 1, 0, 1, 1'b1, 10, 1, 1'b0, 1'b0, 1'b0);
    chk("loaduse_stall", int'(stall), 1);
    chk("loaduse_sel0", int'(fwd_rs_sel), 0);
    tick();
    chk("loaduse_release", int'(stall), 0);
    chk("loaduse_rel_sel", int'(fwd_rs_sel), 0);
    tick();
    drain();

    // ori $9 (tnew 1), beq reads $9 with tuse 0
    drive(1'b1, 0, 3, 0, 3, 1'b1, 9, 1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 9, 0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("beq_stall", int'(stall), 1);
    tick();
    chk("beq_release", int'(stall), 0);
    chk("beq_fwd_m", int'(fwd_rs_sel), 2);
    tick();
    drain();

    // producer writes $0; consumer of $0 sees nothing
    drive(1'b1, 0, 3, 0, 3, 1'b1, 0, 2, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 0, 0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("r0_stall", int'(stall), 0);
    chk("r0_fwd_rs", int'(fwd_rs_sel), 0);
    chk("r0_fwd_rt", int'(fwd_rt_sel), 0);
    tick();
    drain();

    // rt path: $7 tnew 2, tuse 0 -> two stall cycles then forward from W
    drive(1'b1, 0, 3, 0, 3, 1'b1, 7, 2, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 0, 3, 7, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("rt_stall_1", int'(stall), 1);
    tick();
    chk("rt_stall_2", int'(stall), 1);
    tick();
    chk("rt_release", int'(stall), 0);
    chk("rt_fwd_w", int'(fwd_rt_sel), 3);
    tick();
    drain();

    // two producers of $5: E has tnew 1, M has tnew 0; youngest wins
    drive(1'b1, 0, 3, 0, 3, 1'b1, 5, 1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 0, 3, 0, 3, 1'b1, 5, 1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5, 1, 0, 3, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("young_stall", int'(stall), 0);
    chk("young_fwd", int'(fwd_rs_sel), 0);
    drive(1'b1, 5, 0, 0, 3, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("young_tuse0_stall", int'(stall), 1);
    tick();
    drain();

    // tnew 3 producer: tuse all-ones never matches, tuse 2 stalls
    drive(1'b1, 0, 3, 0, 3, 1'b1, 6, 3, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 6, 3, 0, 3, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("tuse_none_stall", int'(stall), 0);
    chk("tuse_none_fwd", int'(fwd_rs_sel), 0);
    drive(1'b1, 6, 2, 0, 3, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("tuse2_stall", int'(stall), 1);
    drain();

    // mult then mflo: exactly 5 stall cycles
    drive(1'b1, 0, 3, 0, 3, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    chk("mult_issue_stall", int'(stall), 0);
    chk("mult_issue_busy", int'(md_busy), 0);
    tick();
    drive(1'b1, 0, 3, 0, 3, 1'b1, 2, 1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("mflo_stall_%0d", i), int'(stall), 1);
      chk($sformatf("mflo_busy_%0d", i), int'(md_busy), 1);
      tick();
    end
    chk("mflo_release", int'(stall), 0);
    chk("mflo_busy_fall", int'(md_busy), 0);
    tick();
    drain();

    // div, then mfhi waits; reset mid-divide clears everything immediately
    drive(1'b1, 0, 3, 0, 3, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 0, 3, 0, 3, 1'b1, 3, 1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("mfhi_stall_%0d", i), int'(stall), 1);
      tick();
    end
    chk("div_busy_c4", int'(md_busy), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_div_busy", int'(md_busy), 0);
    chk("rst_div_stall", int'(stall), 0);
    #1 rst_n = 1'b1;
    #1;
    chk("post_rst_stall", int'(stall), 0);
    tick();
    nop();
    chk("post_rst_busy", int'(md_busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard unit for the pipelined MIPS core. It tracks every in-flight register write across `STAGES` pipeline stages after Decode, using the per-instruction Tuse/Tnew codes produced by the main decoder. From these it generates the Decode-stage stall and the forwarding selects. It also owns a multiply/divide busy counter that stalls HI/LO consumers until the unit is free.

## Interface
Parameters:
- `STAGES`, 3: in-flight stages after D (entry 0 = E, 1 = M, 2 = W).
- `TW`, 2: width of Tuse/Tnew codes.
- `MULT_CYCLES`, 5: busy cycles after a multiply issues.
- `DIV_CYCLES`, 10: busy cycles after a divide issues.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `d_valid`  in  1  Decode holds a real instruction (0 for NOP or bubble).
- `d_rs`, `d_rt`  in  5  source register addresses.
- `d_tuse_rs`, `d_tuse_rt`  in  TW  cycles until the operand is needed; all-ones means "not read".
- `d_regwrite`  in  1  instruction writes the GPR file.
- `d_wreg`  in  5  destination register.
- `d_tnew`  in  TW  cycles until the result exists, counted from entry into E.
- `d_md_start`  in  1  instruction is mult/multu/div/divu.
- `d_md_kind`  in  1  0 = multiply, 1 = divide.
- `d_md_use`  in  1  instruction reads or writes HI/LO (mfhi/mflo/mthi/mtlo).
- `stall`  out  1  freeze PC and the D register; insert a bubble into E.
- `fwd_rs_sel`, `fwd_rt_sel`  out  $clog2(STAGES+1)  0 = register file; k+1 = forward from entry k.
- `md_busy`  out  1  mult/div unit occupied.

## Operation
- **Scoreboard.** `STAGES` entries, each holding {valid, wreg, tnew}.
- **Per rising edge:**
  - Entry k+1 takes entry k, with tnew decremented and saturating at 0. The last entry retires.
  - Entry 0 takes {d_valid & d_regwrite & (d_wreg != 0) & !stall, d_wreg, d_tnew}. A stall therefore inserts an invalid entry.
- **Match.** For each source operand, the match is the lowest-index (youngest) valid entry whose wreg equals the source. Source $0 never matches. Tuse = all-ones never matches.
- **Data stall.** Asserted when a match has tnew > tuse.
- **Forwarding.**
  - Match with tnew == 0: sel = k+1.
  - No match, or match with tnew != 0: sel = 0.
  - Only the youngest match is considered. An older ready entry is ignored.
- **Mult/div counter.**
  - Loaded when d_valid & d_md_start & !stall: MULT_CYCLES if d_md_kind = 0, DIV_CYCLES if 1.
  - Otherwise decrements toward 0 each cycle.
  - md_busy = (count != 0).
- **MD stall.** Asserted when d_valid & (d_md_use | d_md_start) & md_busy.
- **Total stall.** stall = data stall (rs) | data stall (rt) | MD stall.
- **Counter width.** Counter width is $clog2(max(MULT_CYCLES, DIV_CYCLES) + 1).

## Timing
- stall, fwd_*_sel and md_busy are combinational from state and the current D inputs. State updates on the rising edge.
- **Reset.** While rst_n = 0:
  - All entries are invalid and the counter is 0.
  - Outputs: stall = 0 unless an MD stall is impossible (it is, since the counter is 0), so stall = 0; fwd selects = 0; md_busy = 0.
  - Reset takes effect immediately, without waiting for a clock edge. This applies mid-operation too: an in-progress divide is aborted.
- **Data-hazard latency.** Stall lasts exactly max(0, tnew − tuse) cycles for a single producer.
- **MD latency.** After a multiply issues at edge t, md_busy is 1 for edges t+1 … t+MULT_CYCLES. A HI/LO consumer is released on the cycle md_busy falls.
- **Simultaneous data and MD stall.** stall is asserted once. The MD counter still decrements during a data stall.
- **Stalled D instruction.** Never enters the scoreboard and never loads the MD counter.

## Structure
- **Package `hazard_pkg`:**
  - TUSE_NONE (all-ones).
  - MD_KIND_MULT = 0, MD_KIND_DIV = 1.
  - FWD_RF = 0.
  - Default MULT_CYCLES and DIV_CYCLES.
- **Sub-module `md_busy_counter`:** load, kind, count, busy. Instantiated once.
- Scoreboard entries are a generate-loop shift register in the top module.

## Test plan
- **Load-use.** lw $8 (tnew 2) then addu reading $8 (tuse_rs 1) → stall = 1 for exactly 1 cycle. Next cycle: stall = 0, fwd_rs_sel = 0.
- **Branch after ori.** ori $9 (tnew 1) then beq reading $9 (tuse 0) → 1 stall cycle, then fwd_rs_sel = 2 (M).
- **$0 destination.** Producer writes $0 with tnew 2; consumer of $0 with tuse 0 → stall = 0, sel = 0.
- **Youngest match wins.** Two producers of $5 in E (tnew 1) and M (tnew 0); consumer with tuse 1 → stall = 0, fwd sel = 0, not 2.
- **Multiply then mflo.** mult, then mflo back-to-back → stall for exactly MULT_CYCLES = 5 cycles. md_busy falls on the release cycle.
- **Reset mid-divide.** div issued, rst_n pulled low on cycle 4 → md_busy = 0 and stall = 0 immediately. After release, mfhi proceeds with no stall.
